// File: rtl/sm83_mem_model.sv
// sm83 core-bus memory model: req/ready/ack port with wait states, a write-protected ROM
// window and a reset-time sweep that loads a boot image and fills the rest of the array.
`timescale 1ns/1ps
module sm83_mem_model #(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ROM_SIZE    = 0,
    parameter logic [7:0]  FILL_BYTE   = 8'hff,
    parameter int unsigned BOOT_LEN    = 3,
    parameter logic [8*((BOOT_LEN > 0) ? BOOT_LEN : 1)-1:0] BOOT_IMAGE = 24'h3cbe3e
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        init_done
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BW        = 8 * ((BOOT_LEN > 0) ? BOOT_LEN : 1);
    localparam logic [15:0] INIT_LAST = 16'(DEPTH - 1);
    localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
    localparam logic [16:0] ROM_L     = 17'(ROM_SIZE);

    if (DEPTH < 1 || DEPTH > 65536) begin : gDepthErr
        $error("sm83_mem_model: DEPTH must be in 1..65536");
    end
    if (BOOT_LEN > DEPTH) begin : gBootErr
        $error("sm83_mem_model: BOOT_LEN exceeds DEPTH");
    end
    if (ROM_SIZE > DEPTH) begin : gRomErr
        $error("sm83_mem_model: ROM_SIZE exceeds DEPTH");
    end
    if (WAIT_STATES > 15) begin : gWaitErr
        $error("sm83_mem_model: WAIT_STATES exceeds 15");
    end

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] initCnt_q, initCnt_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic        we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        err_q;

    logic [7:0]  mem [DEPTH];

    logic          access;
    logic          accept;
    logic          accWe;
    logic [15:0]   accAddr;
    logic [7:0]    accWdata;
    logic          inRange;
    logic          accErr;
    logic          memWe;
    logic [AW-1:0] memIdx;
    logic [7:0]    memWdata;
    logic [BW-1:0] bootShift;
    logic [7:0]    initByte;

    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        waitCnt_d = waitCnt_q;
        access    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                initCnt_d = initCnt_q + 16'd1;
                if (initCnt_q == INIT_LAST) begin
                    state_d   = S_IDLE;
                    initCnt_d = '0;
                end
            end
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d   = S_WAIT;
                        waitCnt_d = '0;
                    end else begin
                        state_d = S_RESP;
                        access  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (waitCnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                    access  = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so use the live inputs.
    assign accept   = (state_q == S_IDLE) && req;
    assign accWe    = (state_q == S_IDLE) ? we    : we_q;
    assign accAddr  = (state_q == S_IDLE) ? addr  : addr_q;
    assign accWdata = (state_q == S_IDLE) ? wdata : wdata_q;
    assign inRange  = {1'b0, accAddr} < DEPTH_L;
    assign accErr   = !inRange || (accWe && ({1'b0, accAddr} < ROM_L));

    assign bootShift = BOOT_IMAGE >> {initCnt_q, 3'b000};
    assign initByte  = ({16'd0, initCnt_q} < BOOT_LEN) ? bootShift[7:0] : FILL_BYTE;

    assign memWe    = (state_q == S_INIT) || (access && accWe && !accErr);
    assign memIdx   = (state_q == S_INIT) ? initCnt_q[AW-1:0] : accAddr[AW-1:0];
    assign memWdata = (state_q == S_INIT) ? initByte : accWdata;

    // The array carries no reset so that it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memIdx] <= memWdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            initCnt_q <= '0;
            waitCnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
            waitCnt_q <= waitCnt_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (access) begin
                err_q <= accErr;
                if (!accWe) begin
                    rdata_q <= inRange ? mem[memIdx] : FILL_BYTE;
                end
            end
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign ack       = (state_q == S_RESP);
    assign err       = ack && err_q;
    assign rdata     = rdata_q;
    assign init_done = (state_q != S_INIT);

endmodule

// File: tb/tb_sm83_mem_model.sv
// Scoreboard bench for sm83_mem_model: a default instance and a small, slow, ROM-protected one.
`timescale 1ns/1ps
module tb_sm83_mem_model;

    typedef struct packed {
        logic [7:0]  rdata;
        logic        err;
        logic [31:0] acc;
        logic [31:0] lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;

    logic       readyA, ackA, errA, initDoneA;
    logic [7:0] rdataA;
    logic       readyB, ackB, errB, initDoneB;
    logic [7:0] rdataB;
    logic       ready, ack, err, initDone;
    logic [7:0] rdata;

    int          nAssert = 0;
    int          nFail = 0;
    int          ackCount = 0;
    int unsigned cycle = 0;
    exp_t        expQ[$];
    exp_t        monE;
    logic [7:0]  lastRead [0:1];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    sm83_mem_model dutA (
        .clk(clk), .rst_n(rst_n), .req(req && !sel), .we(we), .addr(addr), .wdata(wdata),
        .ready(readyA), .ack(ackA), .rdata(rdataA), .err(errA), .init_done(initDoneA)
    );

    sm83_mem_model #(.DEPTH(256), .WAIT_STATES(2), .ROM_SIZE(16)) dutB (
        .clk(clk), .rst_n(rst_n), .req(req && sel), .we(we), .addr(addr), .wdata(wdata),
        .ready(readyB), .ack(ackB), .rdata(rdataB), .err(errB), .init_done(initDoneB)
    );

    assign ready    = sel ? readyB    : readyA;
    assign ack      = sel ? ackB      : ackA;
    assign err      = sel ? errB      : errA;
    assign rdata    = sel ? rdataB    : rdataA;
    assign initDone = sel ? initDoneB : initDoneA;

    // Scoreboard: every ack of the selected instance must match the oldest pending expectation.
    always @(negedge clk) begin
        nAssert++;
        if (!ack && err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL err_without_ack: got %b expected 0", err);
        end
        nAssert++;
        if ((sel ? ackA : ackB) !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL stray_ack: unselected instance acked (sel=%0d)", sel);
        end
        if (ack === 1'b1) begin
            ackCount++;
            nAssert++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL unexpected_ack: ack at cycle %0d with nothing pending", cycle);
            end else begin
                monE = expQ.pop_front();
                if (rdata !== monE.rdata) begin
                    nFail++;
                    $display("[TB] FAIL rdata: got %h expected %h", rdata, monE.rdata);
                end
                nAssert++;
                if (err !== monE.err) begin
                    nFail++;
                    $display("[TB] FAIL err: got %b expected %b", err, monE.err);
                end
                nAssert++;
                if (cycle - monE.acc !== monE.lat) begin
                    nFail++;
                    $display("[TB] FAIL latency: got %0d expected %0d", cycle - monE.acc, monE.lat);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] expR, input logic expE);
        exp_t e;
        bit   got = 0;
        @(posedge clk);
        #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            nAssert++; nFail++;
            $display("[TB] FAIL accept_timeout: addr %h never accepted", a);
            req = 1'b0;
            return;
        end
        e.rdata = w ? lastRead[sel] : expR;
        e.err   = expE;
        e.acc   = cycle;
        e.lat   = sel ? 32'd3 : 32'd1;
        if (!w) lastRead[sel] = expR;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(posedge clk);
            if (expQ.size() == 0) break;
        end
        if (expQ.size() != 0) begin
            nAssert++; nFail++;
            $display("[TB] FAIL ack_timeout: addr %h never acked", a);
            expQ.delete();
        end
    endtask

    task automatic waitInit(output int doneA, output int doneB, output bit earlyReady);
        doneA = 0; doneB = 0; earlyReady = 0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if ((readyA && !initDoneA) || (readyB && !initDoneB)) earlyReady = 1;
            if (initDoneB && doneB == 0) doneB = k;
            if (initDoneA && doneA == 0) begin
                doneA = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int  doneA, doneB;
        bit  early;
        lastRead[0] = 8'h00;
        lastRead[1] = 8'h00;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            nAssert++;
            if ({ready, ack, rdata, err, initDone} !== 12'h000) begin
                nFail++;
                $display("[TB] FAIL reset_outputs%0d: got %h expected 000", s,
                         {ready, ack, rdata, err, initDone});
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        waitInit(doneA, doneB, early);
        nAssert++;
        if (doneA != 4096) begin
            nFail++;
            $display("[TB] FAIL init_len_A: got %0d expected 4096", doneA);
        end
        nAssert++;
        if (doneB != 256) begin
            nFail++;
            $display("[TB] FAIL init_len_B: got %0d expected 256", doneB);
        end
        nAssert++;
        if (early !== 1'b0 || readyA !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL ready_during_init: early=%b readyA=%b expected early=0 readyA=1",
                     early, readyA);
        end
    endtask

    task automatic test_boot_image();
        sel = 1'b0;
        issue(1'b0, 16'h0000, 8'h00, 8'h3e, 1'b0);
        issue(1'b0, 16'h0001, 8'h00, 8'hbe, 1'b0);
        issue(1'b0, 16'h0002, 8'h00, 8'h3c, 1'b0);
        issue(1'b0, 16'h0003, 8'h00, 8'hff, 1'b0);
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        issue(1'b1, 16'h0100, 8'h55, 8'h00, 1'b0);
        issue(1'b0, 16'h0100, 8'h00, 8'h55, 1'b0);
        issue(1'b0, 16'h0101, 8'h00, 8'hff, 1'b0);
        issue(1'b1, 16'h0fff, 8'ha5, 8'h00, 1'b0);
        issue(1'b0, 16'h0fff, 8'h00, 8'ha5, 1'b0);
        issue(1'b0, 16'h1000, 8'h00, 8'hff, 1'b1);
    endtask

    task automatic test_back_to_back();
        int unsigned prevAcc = 0;
        int          accepts = 0;
        exp_t        e;
        sel = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 16'h0001;
        for (int k = 0; k < 40 && accepts < 4; k++) begin
            @(negedge clk);
            if (ready) begin
                e.rdata = 8'hbe; e.err = 1'b0; e.acc = cycle; e.lat = 32'd3;
                expQ.push_back(e);
                if (accepts > 0) begin
                    nAssert++;
                    if (cycle - prevAcc != 4) begin
                        nFail++;
                        $display("[TB] FAIL accept_spacing: got %0d expected 4", cycle - prevAcc);
                    end
                end
                prevAcc = cycle;
                accepts++;
            end
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        lastRead[1] = 8'hbe;
        nAssert++;
        if (accepts != 4) begin
            nFail++;
            $display("[TB] FAIL accept_count: got %0d expected 4", accepts);
        end
        for (int n = 0; n < 64; n++) begin
            @(posedge clk);
            if (expQ.size() == 0) break;
        end
        nAssert++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("[TB] FAIL b2b_drain: got %0d pending expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_rom();
        sel = 1'b1;
        issue(1'b1, 16'h0002, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 16'h0002, 8'h00, 8'h3c, 1'b0);
        issue(1'b1, 16'h000f, 8'h99, 8'h00, 1'b1);
        issue(1'b0, 16'h000f, 8'h00, 8'hff, 1'b0);
        issue(1'b1, 16'h0010, 8'h5a, 8'h00, 1'b0);
        issue(1'b0, 16'h0010, 8'h00, 8'h5a, 1'b0);
    endtask

    task automatic test_range();
        sel = 1'b1;
        issue(1'b0, 16'h0100, 8'h00, 8'hff, 1'b1);
        issue(1'b1, 16'h8000, 8'h12, 8'h00, 1'b1);
        issue(1'b0, 16'h0000, 8'h00, 8'h3e, 1'b0);
        issue(1'b0, 16'h00ff, 8'h00, 8'hff, 1'b0);
    endtask

    task automatic test_reset_midwait();
        int  doneA, doneB;
        int  acksBefore;
        bit  got = 0;
        bit  early;
        sel = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 8'h77;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        nAssert++;
        if (!got) begin
            nFail++;
            $display("[TB] FAIL midwait_accept: got no accept expected one");
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        acksBefore = ackCount;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            nAssert++;
            if ({ready, ack, rdata, err, initDone} !== 12'h000) begin
                nFail++;
                $display("[TB] FAIL midwait_reset_outputs%0d: got %h expected 000", s,
                         {ready, ack, rdata, err, initDone});
            end
        end
        sel = 1'b1;
        repeat (5) @(negedge clk);
        expQ.delete();
        lastRead[0] = 8'h00;
        lastRead[1] = 8'h00;
        nAssert++;
        if (ackCount != acksBefore) begin
            nFail++;
            $display("[TB] FAIL dropped_request_acked: got %0d acks expected %0d",
                     ackCount, acksBefore);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h0000;
        repeat (10) @(negedge clk);
        req = 1'b0;
        waitInit(doneA, doneB, early);
        nAssert++;
        if (doneA == 0) begin
            nFail++;
            $display("[TB] FAIL reinit_timeout: got init_done=%b expected 1", initDoneA);
        end
        issue(1'b0, 16'h0010, 8'h00, 8'hff, 1'b0);
        sel = 1'b0;
        issue(1'b0, 16'h0100, 8'h00, 8'hff, 1'b0);
        issue(1'b0, 16'h0000, 8'h00, 8'h3e, 1'b0);
    endtask

    initial begin
        test_reset();
        test_boot_image();
        test_write_read();
        test_back_to_back();
        test_rom();
        test_range();
        test_reset_midwait();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
